// File: rtl/ts_pkg.sv
// Shared constants and state encoding for the TS recorder input path.
package ts_pkg;

    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
    localparam int         TS_PKT_LEN   = 188;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCK   = 2'b10
    } ts_state_e;

endpackage

// File: rtl/ts_packet_aligner_if.sv
// Byte-stream bundle between the TS input pins, the aligner and its consumer.
interface ts_packet_aligner_if;

    logic        TS_VALID_IN;
    logic        TS_SYNC_IN;
    logic [7:0]  TS_DATA_IN;
    logic        TS_VALID_OUT;
    logic        TS_SYNC_OUT;
    logic [7:0]  TS_DATA_OUT;
    logic        LOCKED;
    logic [15:0] PKT_COUNT;
    logic [15:0] ERR_COUNT;

    modport master (
        output TS_VALID_IN, TS_SYNC_IN, TS_DATA_IN,
        input  TS_VALID_OUT, TS_SYNC_OUT, TS_DATA_OUT, LOCKED, PKT_COUNT, ERR_COUNT
    );

    modport slave (
        input  TS_VALID_IN, TS_SYNC_IN, TS_DATA_IN,
        output TS_VALID_OUT, TS_SYNC_OUT, TS_DATA_OUT, LOCKED, PKT_COUNT, ERR_COUNT
    );

endinterface

// File: rtl/ts_sat_counter.sv
// Saturating event counter used for status statistics; sticks at all-ones.
module ts_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;

    // Counter register: reset/clear to zero, increment until saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ts_packet_aligner.sv
// Finds MPEG-TS packet boundaries from the sync byte and forwards only aligned
// packets, with a regenerated SYNC flag, once lock is established.
module ts_packet_aligner
    import ts_pkg::*;
#(
    parameter int         PKT_LEN      = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
    parameter int         LOCK_COUNT   = 3,
    parameter int         UNLOCK_COUNT = 3
) (
    input  logic               TS_CLOCK_IN,
    input  logic               TS_RESET,
    ts_packet_aligner_if.slave ts
);

    localparam int POS_W  = $clog2(PKT_LEN);
    localparam int HITS_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
    localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(PKT_LEN - 1);
    localparam logic [HITS_W-1:0] HITS_TARGET = HITS_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_TARGET = MISS_W'(UNLOCK_COUNT);

    ts_state_e         state_r;
    ts_state_e         state_nxt_s;
    logic [POS_W-1:0]  pos_r;
    logic [POS_W-1:0]  pos_nxt_s;
    logic [POS_W-1:0]  pos_inc_s;
    logic [HITS_W-1:0] hits_r;
    logic [HITS_W-1:0] hits_nxt_s;
    logic [HITS_W-1:0] hits_inc_s;
    logic [MISS_W-1:0] misses_r;
    logic [MISS_W-1:0] misses_nxt_s;
    logic [MISS_W-1:0] misses_inc_s;

    logic              valid_out_r;
    logic              sync_out_r;
    logic [7:0]        data_out_r;
    logic              locked_r;
    logic [15:0]       pkt_count_r;
    logic              valid_out_nxt_s;
    logic              sync_out_nxt_s;
    logic [7:0]        data_out_nxt_s;
    logic              pkt_inc_s;
    logic              err_inc_s;
    logic [15:0]       err_count_s;

    logic              at_sync_s;
    logic              sync_hit_s;
    logic              unused_sync_hint_s;

    // The upstream sync hint is deliberately not trusted for alignment.
    assign unused_sync_hint_s = ts.TS_SYNC_IN;

    assign at_sync_s    = (pos_r == {POS_W{1'b0}});
    assign sync_hit_s   = (ts.TS_DATA_IN == SYNC_BYTE);
    assign pos_inc_s    = (pos_r == POS_LAST) ? {POS_W{1'b0}} : (pos_r + POS_W'(1));
    assign hits_inc_s   = hits_r + HITS_W'(1);
    assign misses_inc_s = misses_r + MISS_W'(1);

    // Next-state, position/hit/miss bookkeeping and next output values.
    always_comb begin
        state_nxt_s     = state_r;
        pos_nxt_s       = pos_r;
        hits_nxt_s      = hits_r;
        misses_nxt_s    = misses_r;
        valid_out_nxt_s = 1'b0;
        sync_out_nxt_s  = 1'b0;
        data_out_nxt_s  = 8'h00;
        pkt_inc_s       = 1'b0;
        err_inc_s       = 1'b0;
        if (ts.TS_VALID_IN) begin
            pos_nxt_s = pos_inc_s;
            case (state_r)
                HUNT: begin
                    if (sync_hit_s) begin
                        state_nxt_s = VERIFY;
                        hits_nxt_s  = HITS_W'(1);
                        pos_nxt_s   = POS_W'(1);
                    end else begin
                        pos_nxt_s   = {POS_W{1'b0}};
                    end
                end
                VERIFY: begin
                    if (at_sync_s && sync_hit_s) begin
                        hits_nxt_s = hits_inc_s;
                        if (hits_inc_s == HITS_TARGET) begin
                            state_nxt_s     = LOCK;
                            misses_nxt_s    = {MISS_W{1'b0}};
                            valid_out_nxt_s = 1'b1;
                            sync_out_nxt_s  = 1'b1;
                            data_out_nxt_s  = ts.TS_DATA_IN;
                            pkt_inc_s       = 1'b1;
                        end else begin
                            state_nxt_s     = VERIFY;
                        end
                    end else if (at_sync_s) begin
                        // The failing byte is not reconsidered as a new candidate.
                        state_nxt_s = HUNT;
                        hits_nxt_s  = {HITS_W{1'b0}};
                    end else begin
                        state_nxt_s = VERIFY;
                    end
                end
                LOCK: begin
                    valid_out_nxt_s = 1'b1;
                    sync_out_nxt_s  = at_sync_s;
                    data_out_nxt_s  = ts.TS_DATA_IN;
                    pkt_inc_s       = at_sync_s;
                    if (at_sync_s && sync_hit_s) begin
                        misses_nxt_s = {MISS_W{1'b0}};
                    end else if (at_sync_s) begin
                        misses_nxt_s = misses_inc_s;
                        err_inc_s    = 1'b1;
                        if (misses_inc_s == MISS_TARGET) begin
                            // Truncate: the unlocking byte is already withheld.
                            state_nxt_s     = HUNT;
                            hits_nxt_s      = {HITS_W{1'b0}};
                            misses_nxt_s    = {MISS_W{1'b0}};
                            valid_out_nxt_s = 1'b0;
                            sync_out_nxt_s  = 1'b0;
                            data_out_nxt_s  = 8'h00;
                            pkt_inc_s       = 1'b0;
                        end else begin
                            state_nxt_s     = LOCK;
                        end
                    end else begin
                        state_nxt_s = LOCK;
                    end
                end
                default: begin
                    state_nxt_s  = HUNT;
                    pos_nxt_s    = {POS_W{1'b0}};
                    hits_nxt_s   = {HITS_W{1'b0}};
                    misses_nxt_s = {MISS_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge TS_CLOCK_IN) begin
        if (TS_RESET) begin
            state_r     <= HUNT;
            pos_r       <= {POS_W{1'b0}};
            hits_r      <= {HITS_W{1'b0}};
            misses_r    <= {MISS_W{1'b0}};
            valid_out_r <= 1'b0;
            sync_out_r  <= 1'b0;
            data_out_r  <= 8'h00;
            locked_r    <= 1'b0;
            pkt_count_r <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            pos_r       <= pos_nxt_s;
            hits_r      <= hits_nxt_s;
            misses_r    <= misses_nxt_s;
            valid_out_r <= valid_out_nxt_s;
            sync_out_r  <= sync_out_nxt_s;
            data_out_r  <= data_out_nxt_s;
            locked_r    <= (state_nxt_s == LOCK);
            pkt_count_r <= pkt_inc_s ? (pkt_count_r + 16'h0001) : pkt_count_r;
        end
    end

    ts_sat_counter #(
        .WIDTH (16)
    ) u_err_count (
        .clk   (TS_CLOCK_IN),
        .rst   (TS_RESET),
        .clear (1'b0),
        .inc   (err_inc_s),
        .count (err_count_s)
    );

    assign ts.TS_VALID_OUT = valid_out_r;
    assign ts.TS_SYNC_OUT  = sync_out_r;
    assign ts.TS_DATA_OUT  = data_out_r;
    assign ts.LOCKED       = locked_r;
    assign ts.PKT_COUNT    = pkt_count_r;
    assign ts.ERR_COUNT    = err_count_s;

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Directed bench for ts_packet_aligner: stimulus table, packet-level reference
// model evaluated ahead of time, per-cycle compare process, literal pins.
module tb_ts_packet_aligner;
    import ts_pkg::*;

    localparam int PKT_LEN  = 188;
    localparam int LOCK_N   = 3;
    localparam int UNLOCK_N = 3;

    typedef struct {
        bit         rst;
        bit         v;
        bit         si;
        logic [7:0] d;
    } stim_t;

    typedef struct {
        bit         v;
        bit         s;
        logic [7:0] d;
        bit         lock;
        int         pkt;
        int         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sc_rst;
    logic       sc_clr;
    logic       sc_inc;
    logic [3:0] sc_cnt;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cur_idx = 0;
    bit    active = 1'b0;
    int    base1, base2, base3, base4, base5;

    always #5 clk = ~clk;

    ts_packet_aligner_if ts_if();

    ts_packet_aligner #(
        .PKT_LEN      (PKT_LEN),
        .SYNC_BYTE    (8'h47),
        .LOCK_COUNT   (LOCK_N),
        .UNLOCK_COUNT (UNLOCK_N)
    ) dut (
        .TS_CLOCK_IN (clk),
        .TS_RESET    (rst),
        .ts          (ts_if)
    );

    ts_sat_counter #(
        .WIDTH (4)
    ) sc (
        .clk   (clk),
        .rst   (sc_rst),
        .clear (sc_clr),
        .inc   (sc_inc),
        .count (sc_cnt)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input bit r, input bit v, input logic [7:0] d, input bit si);
        stim_t e;
        e.rst = r;
        e.v   = v;
        e.d   = d;
        e.si  = si;
        stim_q.push_back(e);
    endtask

    function automatic logic [7:0] pay(input int j);
        logic [7:0] b;
        b = 8'((j * 7 + 3) & 255);
        if (b == 8'h47) b = 8'h46;
        return b;
    endfunction

    // One packet; gapped packets insert an invalid cycle carrying 0x47 after each byte.
    task automatic add_pkt(input logic [7:0] sb, input bit gap);
        for (int j = 0; j < PKT_LEN; j++) begin
            add(1'b0, 1'b1, (j == 0) ? sb : pay(j), (j == 5));
            if (gap) add(1'b0, 1'b0, 8'h47, 1'b1);
        end
    endtask

    // Reference: packets are anchored at the sync candidate's valid-byte index.
    function automatic void run_model();
        int mode = 0;
        int anchor = 0;
        int vidx = 0;
        int hits = 0;
        int misses = 0;
        int pkt = 0;
        int err = 0;
        for (int c = 0; c < stim_q.size(); c++) begin
            exp_t e;
            int   off;
            bit   good;
            e.v = 1'b0;
            e.s = 1'b0;
            e.d = 8'h00;
            if (stim_q[c].rst) begin
                mode = 0; hits = 0; misses = 0; pkt = 0; err = 0; vidx = 0; anchor = 0;
            end else if (stim_q[c].v) begin
                off  = (vidx - anchor) % PKT_LEN;
                good = (stim_q[c].d == 8'h47);
                case (mode)
                    0: begin
                        if (good) begin
                            mode = 1; anchor = vidx; hits = 1;
                        end
                    end
                    1: begin
                        if (off == 0 && good) begin
                            hits++;
                            if (hits == LOCK_N) begin
                                mode = 2; misses = 0;
                                e.v = 1'b1; e.s = 1'b1; e.d = stim_q[c].d;
                            end
                        end else if (off == 0) begin
                            mode = 0;
                        end
                    end
                    default: begin
                        e.v = 1'b1;
                        e.d = stim_q[c].d;
                        e.s = (off == 0);
                        if (off == 0 && good) begin
                            misses = 0;
                        end else if (off == 0) begin
                            misses++;
                            if (err < 65535) err++;
                            if (misses == UNLOCK_N) begin
                                mode = 0;
                                e.v = 1'b0; e.s = 1'b0; e.d = 8'h00;
                            end
                        end
                    end
                endcase
                if (e.v && e.s) pkt = (pkt + 1) % 65536;
                vidx++;
            end
            e.lock = (mode == 2);
            e.pkt  = pkt;
            e.err  = err;
            exp_q.push_back(e);
        end
    endfunction

    // Compare process: DUT outputs after edge n against the model entry for input n.
    initial begin
        int idx;
        bit act;
        forever begin
            @(posedge clk);
            idx = cur_idx;
            act = active;
            #1;
            if (act) begin
                chk("valid_out", idx, 32'(ts_if.TS_VALID_OUT), 32'(exp_q[idx].v));
                chk("sync_out",  idx, 32'(ts_if.TS_SYNC_OUT),  32'(exp_q[idx].s));
                chk("data_out",  idx, 32'(ts_if.TS_DATA_OUT),  32'(exp_q[idx].d));
                chk("locked",    idx, 32'(ts_if.LOCKED),       32'(exp_q[idx].lock));
                chk("pkt_count", idx, 32'(ts_if.PKT_COUNT),    32'(exp_q[idx].pkt));
                chk("err_count", idx, 32'(ts_if.ERR_COUNT),    32'(exp_q[idx].err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        ts_if.TS_VALID_IN = 1'b0;
        ts_if.TS_SYNC_IN  = 1'b0;
        ts_if.TS_DATA_IN  = 8'h00;
        sc_rst = 1'b1;
        sc_clr = 1'b0;
        sc_inc = 1'b0;

        add(1'b1, 1'b0, 8'h00, 1'b0);
        add(1'b1, 1'b1, 8'h47, 1'b0);
        base1 = stim_q.size();
        for (int p = 0; p < 6; p++) add_pkt(8'h47, 1'b0);

        add(1'b1, 1'b0, 8'h00, 1'b0);
        base2 = stim_q.size();
        for (int p = 0; p < 4; p++) add_pkt(8'h47, 1'b1);

        add(1'b1, 1'b0, 8'h00, 1'b0);
        base3 = stim_q.size();
        for (int j = 0; j < 20; j++) add(1'b0, 1'b1, (j == 10) ? 8'h47 : pay(j + 100), 1'b0);
        for (int p = 0; p < 7; p++) add_pkt(8'h47, 1'b0);

        add(1'b1, 1'b0, 8'h00, 1'b0);
        base4 = stim_q.size();
        for (int p = 0; p < 11; p++)
            add_pkt((p == 3 || p == 4 || p == 6 || p == 7 || p == 8) ? 8'h00 : 8'h47, 1'b0);

        add(1'b1, 1'b0, 8'h00, 1'b0);
        base5 = stim_q.size();
        for (int p = 0; p < 8; p++) add_pkt(8'h47, 1'b0);
        stim_q[base5 + 3 * PKT_LEN + 90].rst = 1'b1;
        add(1'b1, 1'b0, 8'h00, 1'b0);

        run_model();

        // Hand-derived anchors for the model itself.
        chk("pin_p1_prelock",  base1 + 375, 32'(exp_q[base1 + 375].lock), 32'd0);
        chk("pin_p1_lock",     base1 + 376, 32'(exp_q[base1 + 376].lock), 32'd1);
        chk("pin_p1_first_d",  base1 + 376, 32'(exp_q[base1 + 376].d),    32'h47);
        chk("pin_p1_first_s",  base1 + 376, 32'(exp_q[base1 + 376].s),    32'd1);
        chk("pin_p1_pkt1",     base1 + 376, 32'(exp_q[base1 + 376].pkt),  32'd1);
        chk("pin_p1_pkt2",     base1 + 564, 32'(exp_q[base1 + 564].pkt),  32'd2);
        chk("pin_p2_prelock",  base2 + 750, 32'(exp_q[base2 + 750].lock), 32'd0);
        chk("pin_p2_lock",     base2 + 752, 32'(exp_q[base2 + 752].lock), 32'd1);
        chk("pin_p2_gap",      base2 + 753, 32'(exp_q[base2 + 753].v),    32'd0);
        chk("pin_p3_prelock",  base3 + 583, 32'(exp_q[base3 + 583].lock), 32'd0);
        chk("pin_p3_lock",     base3 + 584, 32'(exp_q[base3 + 584].lock), 32'd1);
        chk("pin_p3_err",      base3 + 584, 32'(exp_q[base3 + 584].err),  32'd0);
        chk("pin_p4_miss1_s",  base4 + 564, 32'(exp_q[base4 + 564].s),    32'd1);
        chk("pin_p4_miss1_d",  base4 + 564, 32'(exp_q[base4 + 564].d),    32'h00);
        chk("pin_p4_err2",     base4 + 752, 32'(exp_q[base4 + 752].err),  32'd2);
        chk("pin_p4_lock2",    base4 + 752, 32'(exp_q[base4 + 752].lock), 32'd1);
        chk("pin_p4_err4",     base4 + 1316, 32'(exp_q[base4 + 1316].err), 32'd4);
        chk("pin_p4_unlock",   base4 + 1504, 32'(exp_q[base4 + 1504].lock), 32'd0);
        chk("pin_p4_unlock_v", base4 + 1504, 32'(exp_q[base4 + 1504].v),  32'd0);
        chk("pin_p4_err5",     base4 + 1504, 32'(exp_q[base4 + 1504].err), 32'd5);
        chk("pin_p5_rst_pkt",  base5 + 654, 32'(exp_q[base5 + 654].pkt),  32'd0);
        chk("pin_p5_rst_lock", base5 + 654, 32'(exp_q[base5 + 654].lock), 32'd0);
        chk("pin_p5_prelock",  base5 + 940, 32'(exp_q[base5 + 940].lock), 32'd0);
        chk("pin_p5_relock",   base5 + 1128, 32'(exp_q[base5 + 1128].pkt), 32'd1);

        for (int c = 0; c < stim_q.size(); c++) begin
            @(negedge clk);
            rst               = stim_q[c].rst;
            ts_if.TS_VALID_IN = stim_q[c].v;
            ts_if.TS_SYNC_IN  = stim_q[c].si;
            ts_if.TS_DATA_IN  = stim_q[c].d;
            cur_idx           = c;
            active            = 1'b1;
        end
        @(negedge clk);
        active = 1'b0;
        ts_if.TS_VALID_IN = 1'b0;

        // Saturation of the shared counter, exercised on a narrow instance.
        @(posedge clk);
        #1;
        chk("sat_reset", 0, 32'(sc_cnt), 32'd0);
        @(negedge clk);
        sc_rst = 1'b0;
        sc_inc = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            chk("sat_count", k, 32'(sc_cnt), (k > 15) ? 32'd15 : 32'(k));
        end
        @(negedge clk);
        sc_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_clear", 21, 32'(sc_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ts_packet_aligner.md
# ts_packet_aligner

- Upstream front-end of the TS recorder path: takes the raw byte stream from the TS input pins and finds the 188-byte MPEG-TS packet boundaries from the 0x47 sync byte.
- After lock, forwards only aligned packets, with a regenerated SYNC on each packet's first byte, to the passthrough/record/replay state machine.
- Drops all bytes while unlocked and reports lock status and sync-error statistics.

## Interface
Parameters:
- PKT_LEN, 188: packet length in bytes; byte-position counter width is $clog2(PKT_LEN).
- SYNC_BYTE, 8'h47: sync byte value.
- LOCK_COUNT, 3: consecutive correctly spaced sync bytes required to lock (≥2).
- UNLOCK_COUNT, 3: consecutive missed sync bytes that drop lock (≥1).

Ports:
- TS_CLOCK_IN  in  1  the block's single clock; all logic on its rising edge.
- TS_RESET  in  1  reset, synchronous and active-high.
- TS_VALID_IN  in  1  byte strobe; counters advance only on valid bytes.
- TS_SYNC_IN  in  1  upstream sync hint; ignored for alignment.
- TS_DATA_IN  in  8  input byte.
- TS_VALID_OUT  out  1  forwarded byte strobe.
- TS_SYNC_OUT  out  1  high with the first byte of each forwarded packet.
- TS_DATA_OUT  out  8  forwarded byte.
- LOCKED  out  1  high while state is LOCK.
- PKT_COUNT  out  16  packets forwarded; wraps.
- ERR_COUNT  out  16  sync misses while locked; saturates at 16'hFFFF.

## Operation
- Byte position pos counts valid bytes from 0 to PKT_LEN-1, then wraps to 0. pos==0 is the expected sync position.
- A "sync check" is a valid byte at pos==PKT_LEN-1+1 after wrap, i.e. the valid byte landing at pos 0 outside HUNT.
- HUNT: pos is don't-care.
  - Valid byte == SYNC_BYTE → VERIFY, hits=1, pos=1 for the next byte.
  - Nothing is forwarded.
- VERIFY:
  - Sync check matches: hits+1. If hits reaches LOCK_COUNT → LOCK, and this byte is forwarded as the first packet byte.
  - Sync check mismatches → HUNT. The mismatching byte is not re-evaluated as a new sync candidate.
  - Nothing is forwarded except the locking byte.
- LOCK:
  - Every valid byte is forwarded. TS_SYNC_OUT=1 on pos-0 bytes, whether or not they match.
  - Sync check match: misses=0.
  - Sync check mismatch: misses+1, ERR_COUNT+1 (saturating).
  - If misses reaches UNLOCK_COUNT → HUNT. That byte and all later bytes are not forwarded. The partially forwarded previous packet is truncated by design, because downstream resyncs on TS_SYNC_OUT.
- PKT_COUNT increments on every forwarded byte with TS_SYNC_OUT=1.
- Invalid input cycles: state, pos and counters hold; TS_VALID_OUT=0 on the matching output cycle.
- TS_RESET (at any time, including mid-packet while locked): state=HUNT, pos=0, hits=0, misses=0, PKT_COUNT=0, ERR_COUNT=0. All outputs are 0 on the cycle after reset is sampled.

## Timing
- Data path latency: exactly 1 cycle. The input byte sampled at edge n appears on TS_*_OUT after edge n, valid through edge n+1. All outputs are registered.
- TS_DATA_OUT is 0 whenever TS_VALID_OUT=0.
- LOCKED rises in the same cycle as the first forwarded byte: TS_VALID_OUT=1, TS_SYNC_OUT=1, TS_DATA_OUT=SYNC_BYTE.
- LOCKED falls in the cycle after the UNLOCK_COUNT-th miss is sampled. TS_VALID_OUT is 0 in that same cycle.
- There is no back-pressure; the downstream stage accepts one byte per cycle.
- Reset has priority over every other event in the same cycle.

## Structure
- Shared package ts_pkg holds:
  - TS_SYNC_BYTE (8'h47)
  - TS_PKT_LEN (188)
  - aligner state encoding: HUNT=2'b00, VERIFY=2'b01, LOCK=2'b10
- The parameters default to these package constants.
- Sub-module ts_sat_counter (parameter WIDTH; inputs clear and inc; saturating) is used for ERR_COUNT and reused by later status blocks.
- Everything else lives in one FSM plus a position counter.

## Test plan
- Clean stream, 0x47 every 188 valid bytes from cycle 0:
  - LOCKED rises one cycle after valid byte 376 (the third sync).
  - First output is VALID=1, SYNC=1, DATA=0x47; PKT_COUNT=1, then increments every 188 bytes.
  - No output before lock.
- Same stream with VALID_IN low every other cycle: lock occurs at the same valid-byte index (376); TS_VALID_OUT mirrors the gaps with 1-cycle delay.
- False 0x47 at payload offset 10 before the true stream alignment: VERIFY fails at the byte 188 after it and returns to HUNT; lock is reached on the true alignment; ERR_COUNT=0.
- Locked, then two consecutive corrupted sync bytes (0x00):
  - LOCKED stays 1, ERR_COUNT=2, TS_SYNC_OUT still asserted on those bytes.
  - A good sync next resets misses.
  - A further three consecutive bad syncs make LOCKED fall; ERR_COUNT=5 and output valid drops at the third.
- TS_RESET pulsed at packet offset 90 while locked: next cycle all outputs are 0 and counters are 0; relock needs three fresh syncs.
- ERR_COUNT preloaded by forcing 65535 misses (locked with UNLOCK_COUNT large): the value holds at 16'hFFFF and does not wrap.
